demorgan_vector_checker: RTL

//   Exhaustive stimulus sequencer and checker for the 3-input De Morgan gate stage.

---
 rtl/demorgan_vector_checker.sv | 113 +++++++++++
 1 files changed

// File: rtl/demorgan_vector_checker.sv
// Exhaustive 8-vector sequencer/checker for a 3-input De Morgan gate (d = ~((a|b)&c)).
// Latency: each vector held SETTLE_CYCLES+1 cycles; done rises 8*(SETTLE_CYCLES+1) cycles after start.
// Backpressure: none; start is ignored while busy and only accepted in IDLE or DONE.
module demorgan_vector_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d_i,
    output logic             a_o,
    output logic             b_o,
    output logic             c_o,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [2:0]       fail_q, fail_d;
    logic [2:0]       stim_q, stim_d;
    logic             exp_d;
    logic             mismatch;

    // Reference form of the gate, evaluated on the vector currently being driven
    assign exp_d    = (~vec_q[2] & ~vec_q[1]) | ~vec_q[0];
    assign mismatch = d_i ^ exp_d;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fail_d  = fail_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    vec_d   = 3'd0;
                    cnt_d   = '0;
                    err_d   = '0;
                    fail_d  = 3'd0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 1'b1;
                    end
                    if (err_q == '0) begin
                        fail_d = vec_q;
                    end
                end
                if (vec_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stimulus register tracks the next vector so it lines up with the state it belongs to
    assign stim_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? vec_d : 3'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= 3'd0;
            cnt_q   <= '0;
            err_q   <= '0;
            fail_q  <= 3'd0;
            stim_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            stim_q  <= stim_d;
        end
    end

    assign {a_o, b_o, c_o} = stim_q;
    assign busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_q == '0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule
